accum_sequencer: RTL and testbench

Sequencing controller for the N-bit accumulator datapath on the board-level accumulator designs. It accepts a start command and an operand count, clears the accumulator, and pulls exactly that many operands over a valid/ready stream. Each accepted operand is added into the running sum. It then reports completion with a one-cycle done pulse and sticky unsigned-carry and signed-overflow flags. It replaces manual key-clocked accumulation with a counted, handshaked run.

---
 rtl/accum_sequencer_pkg.sv | 24 ++
 rtl/accum_add_core.sv | 32 +++
 rtl/accum_sequencer.sv | 157 +++++++++++++++
 tb/tb_accum_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/accum_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : accum_sequencer_pkg                                             |
// | Purpose  : Shared state encoding and default widths for the accumulator    |
// |            sequencer and its adder core.                                   |
// | Contents : state_t   - 2-bit FSM encoding (IDLE/CLEAR/ACCUM/DONE)          |
// |            c_def_n     - default operand/sum width                         |
// |            c_def_cnt_w - default operand-count width                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package accum_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_ACCUM = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int c_def_n     = 8;
   localparam int c_def_cnt_w = 4;

endpackage : accum_sequencer_pkg
`default_nettype wire

// File: rtl/accum_add_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : accum_add_core                                                  |
// | Purpose  : Purely combinational N-bit adder with unsigned carry-out and    |
// |            two's-complement overflow detection.                            |
// | Ports    : a, b  (in,  N) - operands                                       |
// |            s     (out, N) - sum modulo 2^N                                 |
// |            carry (out, 1) - bit N of the (N+1)-bit sum                     |
// |            ovf   (out, 1) - operand signs equal, result sign differs       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module accum_add_core
   import accum_sequencer_pkg::*;
#(
   parameter int N = c_def_n
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s,
   output logic         carry,
   output logic         ovf
);

   logic [N:0] w_sum_ext;

   assign w_sum_ext = {1'b0, a} + {1'b0, b};
   assign s         = w_sum_ext[N-1:0];
   assign carry     = w_sum_ext[N];
   assign ovf       = (a[N-1] == b[N-1]) && (w_sum_ext[N-1] != a[N-1]);

endmodule : accum_add_core
`default_nettype wire

// File: rtl/accum_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : accum_sequencer                                                 |
// | Purpose  : Counted, handshaked accumulation run. A start in IDLE latches   |
// |            len, CLEAR zeroes the sum and flags, ACCUM pulls len operands   |
// |            over valid/ready, DONE pulses done for one cycle.               |
// | Ports    : clk          (in,  1)     - system clock, rising edge           |
// |            aclr         (in,  1)     - async active-low reset              |
// |            start        (in,  1)     - run request, sampled in IDLE        |
// |            len          (in,  CNT_W) - operand count for the run           |
// |            in_data      (in,  N)     - operand                             |
// |            in_valid     (in,  1)     - operand valid                       |
// |            in_ready     (out, 1)     - operand accepted this cycle         |
// |            sum          (out, N)     - registered running sum              |
// |            carry_sticky (out, 1)     - unsigned carry seen during run      |
// |            ovf_sticky   (out, 1)     - signed overflow seen during run     |
// |            busy         (out, 1)     - CLEAR or ACCUM                      |
// |            done         (out, 1)     - one-cycle completion pulse          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module accum_sequencer
   import accum_sequencer_pkg::*;
#(
   parameter int N     = c_def_n,
   parameter int CNT_W = c_def_cnt_w
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic [N-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N-1:0]     sum,
   output logic             carry_sticky,
   output logic             ovf_sticky,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [N-1:0]     r_sum;
   logic             r_carry;
   logic             r_ovf;

   logic             w_busy;
   logic             w_in_ready;
   logic             w_done;
   logic             w_accept;
   logic [N-1:0]     w_add_s;
   logic             w_add_c;
   logic             w_add_v;

   // Handshake decoded straight from the state so it does not depend on the
   // combinational output block below.
   assign w_accept = in_valid && (r_state == ST_ACCUM);

   accum_add_core #(
      .N (N)
   ) u_add (
      .a     (r_sum),
      .b     (in_data),
      .s     (w_add_s),
      .carry (w_add_c),
      .ovf   (w_add_v)
   );

   // State register
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and Moore outputs. Outputs come only from r_state, so they
   // drop to zero the moment reset forces the state to IDLE.
   always_comb begin
      w_next     = r_state;
      w_busy     = 1'b0;
      w_in_ready = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            w_busy = 1'b1;
            w_next = (r_cnt == '0) ? ST_DONE : ST_ACCUM;
         end
         ST_ACCUM: begin
            w_busy     = 1'b1;
            w_in_ready = 1'b1;
            if (w_accept && (r_cnt == c_one)) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Counter, sum and sticky flags. Sum and flags are only touched in CLEAR
   // and on an ACCUM handshake, so they hold through DONE and IDLE.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         r_cnt   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_cnt <= len;
               end
            end
            ST_CLEAR: begin
               r_sum   <= '0;
               r_carry <= 1'b0;
               r_ovf   <= 1'b0;
            end
            ST_ACCUM: begin
               if (w_accept) begin
                  r_sum   <= w_add_s;
                  r_carry <= r_carry | w_add_c;
                  r_ovf   <= r_ovf | w_add_v;
                  r_cnt   <= r_cnt - c_one;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready     = w_in_ready;
   assign busy         = w_busy;
   assign done         = w_done;
   assign sum          = r_sum;
   assign carry_sticky = r_carry;
   assign ovf_sticky   = r_ovf;

endmodule : accum_sequencer
`default_nettype wire

// File: tb/tb_accum_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_accum_sequencer                                              |
// | Purpose  : Directed self-checking bench for accum_sequencer (N=8, CNT_W=4) |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_accum_sequencer;

   logic       clk;
   logic       aclr;
   logic       start;
   logic [3:0] len;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] sum;
   logic       carry_sticky;
   logic       ovf_sticky;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   // results captured in the done cycle of the last run
   int         res_edges;
   int         res_hs;
   logic [7:0] res_sum;
   logic       res_c;
   logic       res_v;

   accum_sequencer #(
      .N     (8),
      .CNT_W (4)
   ) dut (
      .clk          (clk),
      .aclr         (aclr),
      .start        (start),
      .len          (len),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .sum          (sum),
      .carry_sticky (carry_sticky),
      .ovf_sticky   (ovf_sticky),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One run. smode: 0 = plain start pulse, 1 = re-pulse start (len=F) on the
   // second ACCUM cycle, 2 = keep start held high throughout.
   // Operand i is ops[8*i +: 8]; valid pattern bit p applies to the p-th ACCUM
   // cycle, with valid=1 once the pattern is exhausted.
   task automatic run(input string tag, input logic [3:0] l, input logic [31:0] ops,
                      input logic [15:0] vpat, input int npat, input int smode);
      int  e   = 0;
      int  idx = 0;
      int  p   = 0;
      bit  got = 0;
      logic v;
      @(negedge clk);
      start    = 1'b1;
      len      = l;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (smode != 2) start = 1'b0;
      while (!got && e < 60) begin
         if (done) begin
            got = 1;
         end else begin
            if (smode == 1) start = (in_ready && p == 1);
            if (in_ready) begin
               v = (p < npat) ? vpat[p] : 1'b1;
               p++;
               in_valid = v;
               if (v && idx < 4) begin
                  in_data = ops[8*idx +: 8];
                  idx++;
               end else begin
                  in_data = 8'hA5 ^ 8'(p);
               end
            end else begin
               in_valid = 1'b0;
               in_data  = 8'hFF;
            end
            @(posedge clk);
            e++;
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      if (smode == 1) start = 1'b0;
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      res_edges = e;
      res_hs    = idx;
      res_sum   = sum;
      res_c     = carry_sticky;
      res_v     = ovf_sticky;
      @(negedge clk);
      check({tag, "_done_width"}, 32'(done), 32'd0);
   endtask

   initial begin
      aclr     = 1'b0;
      start    = 1'b0;
      len      = 4'd0;
      in_data  = 8'h00;
      in_valid = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_sum", 32'(sum), 32'h0);
      check("rst_flags", {30'd0, carry_sticky, ovf_sticky}, 32'h0);
      check("rst_ctrl", {29'd0, busy, done, in_ready}, 32'h0);
      #2 aclr = 1'b1;

      // basic run
      run("basic", 4'd3, 32'h00_05_20_10, 16'h0, 0, 0);
      check("basic_sum", 32'(res_sum), 32'h35);
      check("basic_flags", {30'd0, res_c, res_v}, 32'h0);
      check("basic_edges", 32'(res_edges), 32'd4);
      check("basic_sum_hold", 32'(sum), 32'h35);

      // carry + overflow
      run("c80", 4'd2, 32'h00_00_80_80, 16'h0, 0, 0);
      check("c80_sum", 32'(res_sum), 32'h00);
      check("c80_flags", {30'd0, res_c, res_v}, 32'h3);

      run("o7f", 4'd2, 32'h00_00_01_7F, 16'h0, 0, 0);
      check("o7f_sum", 32'(res_sum), 32'h80);
      check("o7f_flags", {30'd0, res_c, res_v}, 32'h1);

      run("one", 4'd1, 32'h00_00_00_01, 16'h0, 0, 0);
      check("one_sum", 32'(res_sum), 32'h01);
      check("one_flags", {30'd0, res_c, res_v}, 32'h0);

      // carry early in the run must stick through later carry-free adds
      run("stick", 4'd3, 32'h00_01_20_F0, 16'h0, 0, 0);
      check("stick_sum", 32'(res_sum), 32'h11);
      check("stick_flags", {30'd0, res_c, res_v}, 32'h2);

      // backpressure: valid 1,0,0,1,1,0,1
      run("bp", 4'd4, 32'h04_03_02_01, 16'b1011001, 7, 0);
      check("bp_sum", 32'(res_sum), 32'h0A);
      check("bp_hs", 32'(res_hs), 32'd4);
      check("bp_edges", 32'(res_edges), 32'd8);

      // len = 0
      run("len0", 4'd0, 32'h0, 16'h0, 0, 0);
      check("len0_sum", 32'(res_sum), 32'h00);
      check("len0_edges", 32'(res_edges), 32'd1);
      check("len0_hs", 32'(res_hs), 32'd0);

      // start pulsed during ACCUM with len=F must be ignored
      run("poke", 4'd3, 32'h00_01_01_01, 16'h0, 0, 1);
      check("poke_sum", 32'(res_sum), 32'h03);
      check("poke_edges", 32'(res_edges), 32'd4);
      check("poke_idle", {30'd0, busy, in_ready}, 32'h0);

      // back-to-back with start held high
      run("b2b", 4'd1, 32'h00_00_00_07, 16'h0, 0, 2);
      check("b2b_sum1", 32'(res_sum), 32'h07);
      check("b2b_idle_busy", 32'(busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("b2b_clear_busy", {30'd0, busy, in_ready}, 32'h2);
      check("b2b_clear_sum_hold", 32'(sum), 32'h07);
      @(posedge clk);
      @(negedge clk);
      check("b2b_accum_sum0", 32'(sum), 32'h00);
      check("b2b_accum_ready", 32'(in_ready), 32'd1);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h03;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_done2", 32'(done), 32'd1);
      check("b2b_sum2", 32'(sum), 32'h03);

      // reset mid-run after 2 of 5 operands
      @(negedge clk);
      start = 1'b1;
      len   = 4'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hF0;
      @(negedge clk);
      in_data  = 8'h20;
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_pre_sum", 32'(sum), 32'h10);
      check("mid_pre_c", 32'(carry_sticky), 32'd1);
      check("mid_pre_busy", 32'(busy), 32'd1);
      #1 aclr = 1'b0;
      #1;
      check("mid_rst_sum", 32'(sum), 32'h0);
      check("mid_rst_flags", {30'd0, carry_sticky, ovf_sticky}, 32'h0);
      check("mid_rst_ctrl", {29'd0, busy, done, in_ready}, 32'h0);
      #1 aclr = 1'b1;

      run("after", 4'd1, 32'h00_00_00_42, 16'h0, 0, 0);
      check("after_sum", 32'(res_sum), 32'h42);
      check("after_flags", {30'd0, res_c, res_v}, 32'h0);
      check("after_edges", 32'(res_edges), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // hard stop in case a wait ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_accum_sequencer
`default_nettype wire
